// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles the two requester command/response channels and
// the single-port memory bus used by dmem_arbiter.
//   slave  : arbiter view (samples requests and mem_rdata, drives grants,
//            completions, read data and the memory command).
//   master : environment view (requesters plus memory model).
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic          req0, req1;
    logic          we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1;
    logic          done0, done1;
    logic [DW-1:0] rdata0, rdata1;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, done0, done1, rdata0, rdata1,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, done0, done1, rdata0, rdata1,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one single-port synchronous data
// memory between the CPU load/store port (0) and the debug/loader port (1).
// Each access runs IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> RESP.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    dmem_arbiter_if.slave: req/we/addr/wdata per port in,
//          gnt/done/rdata per port out, mem_en/mem_we/mem_addr/mem_wdata out,
//          mem_rdata in (valid MEM_LAT cycles after mem_en, MEM_LAT in 1..7)
// All outputs are registered.
module dmem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input logic          clk,
    input logic          reset,
    dmem_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [2:0] CNT_LOAD = 3'(MEM_LAT - 1);

    logic [1:0]    state_q, state_d;
    logic          owner_q, owner_d;
    logic          rr_ptr_q, rr_ptr_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic          done0_q, done0_d, done1_q, done1_d;
    logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          win;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        // Lone requester wins outright; a tie goes to the port rr_ptr names.
        win = (bus.req0 & bus.req1) ? rr_ptr_q : bus.req1;

        case (state_q)
            S_IDLE: begin
                if (bus.req0 | bus.req1) begin
                    // The command is latched straight into the registered
                    // memory outputs so gnt and mem_en appear in ISSUE.
                    owner_d     = win;
                    rr_ptr_d    = ~win;
                    mem_we_d    = win ? bus.we1    : bus.we0;
                    mem_addr_d  = win ? bus.addr1  : bus.addr0;
                    mem_wdata_d = win ? bus.wdata1 : bus.wdata0;
                    mem_en_d    = 1'b1;
                    gnt0_d      = ~win;
                    gnt1_d      = win;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = CNT_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Last WAIT cycle: data is captured together with the done
                // pulse so both are visible during RESP.
                if (cnt_q == 3'd0) begin
                    if (owner_q) begin
                        rdata1_d = bus.mem_rdata;
                        done1_d  = 1'b1;
                    end else begin
                        rdata0_d = bus.mem_rdata;
                        done0_d  = 1'b1;
                    end
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            rr_ptr_q    <= 1'b0;
            cnt_q       <= '0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.done0     = done0_q;
    assign bus.done1     = done1_q;
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule
